// File: rtl/mag_pkg.sv
// Shared definitions for the magnitude sort sequencer.
//   - MAG_W           : width of every data word
//   - ST_LOAD/SORT/DRAIN : FSM state encodings
//   - CMP_GT/EQ/LT    : bit positions in the comparator result vector
package mag_pkg;
    localparam int MAG_W = 4;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int CMP_GT = 2;
    localparam int CMP_EQ = 1;
    localparam int CMP_LT = 0;

    typedef enum logic [1:0] {
        S_LOAD  = ST_LOAD,
        S_SORT  = ST_SORT,
        S_DRAIN = ST_DRAIN
    } state_t;
endpackage

// File: rtl/mag4com.sv
// 4-bit unsigned magnitude comparator.
//   a, b : operands
//   o    : {a>b, a==b, a<b}, one-hot
module mag4com
    import mag_pkg::*;
(
    input  logic [MAG_W-1:0] a,
    input  logic [MAG_W-1:0] b,
    output logic [2:0]       o
);
    assign o[CMP_GT] = (a > b);
    assign o[CMP_EQ] = (a == b);
    assign o[CMP_LT] = (a < b);
endmodule

// File: rtl/mag_sort_ctrl.sv
// Load / sort / drain sequencer around one shared mag4com comparator.
// Collects DEPTH words, bubble-sorts them in place (one compare per cycle),
// then streams them out in order.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds data stable while valid is high and ready
// is low; ready never depends on valid.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready/in_data        load stream (accepted only in LOAD)
//   out_valid/out_ready/out_data/out_last  sorted stream (only in DRAIN)
//   busy                  high while sorting or draining
//   swap_cnt              swaps made by the last sort (saturating)
module mag_sort_ctrl
    import mag_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [7:0]       swap_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_CMP = PW'(DEPTH - 2);

    state_t           state;
    logic [MAG_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    cmp_idx;
    logic [PW-1:0]    pass_idx;
    logic             pass_swapped;

    logic [PW-1:0]    nxt_idx;
    logic [MAG_W-1:0] cmp_a;
    logic [MAG_W-1:0] cmp_b;
    logic [2:0]       cmp_o;
    logic             do_swap;

    assign nxt_idx = cmp_idx + ONE;
    assign cmp_a   = mem[cmp_idx];
    assign cmp_b   = mem[nxt_idx];

    mag4com u_cmp (
        .a (cmp_a),
        .b (cmp_b),
        .o (cmp_o)
    );

    // Strict inequality only: equal neighbours stay put, keeping the sort stable.
    assign do_swap = DESCEND ? cmp_o[CMP_LT] : cmp_o[CMP_GT];

    assign in_ready  = (state == S_LOAD) && !rst;
    assign out_valid = (state == S_DRAIN);
    assign out_data  = mem[rd_ptr];
    assign out_last  = out_valid && (rd_ptr == LAST_IDX);
    assign busy      = (state != S_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_LOAD;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cmp_idx      <= '0;
            pass_idx     <= '0;
            pass_swapped <= 1'b0;
            swap_cnt     <= 8'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        mem[wr_ptr] <= in_data;
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr       <= '0;
                            cmp_idx      <= '0;
                            pass_idx     <= '0;
                            pass_swapped <= 1'b0;
                            swap_cnt     <= 8'd0;
                            state        <= S_SORT;
                        end else begin
                            wr_ptr <= wr_ptr + ONE;
                        end
                    end
                end
                S_SORT: begin
                    if (do_swap) begin
                        mem[cmp_idx] <= cmp_b;
                        mem[nxt_idx] <= cmp_a;
                        if (swap_cnt != 8'hFF) swap_cnt <= swap_cnt + 8'd1;
                    end
                    if (cmp_idx == LAST_CMP) begin
                        // End of a pass: a clean pass (this compare included)
                        // or the final possible pass means the buffer is sorted.
                        if (!(pass_swapped || do_swap) || (pass_idx == LAST_CMP)) begin
                            rd_ptr <= '0;
                            state  <= S_DRAIN;
                        end else begin
                            cmp_idx      <= '0;
                            pass_idx     <= pass_idx + ONE;
                            pass_swapped <= 1'b0;
                        end
                    end else begin
                        cmp_idx      <= nxt_idx;
                        pass_swapped <= pass_swapped || do_swap;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr == LAST_IDX) begin
                            rd_ptr <= '0;
                            wr_ptr <= '0;
                            state  <= S_LOAD;
                        end else begin
                            rd_ptr <= rd_ptr + ONE;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_mag_sort_ctrl.sv
// Directed bench for mag_sort_ctrl (DEPTH=8), with a second DESCEND=1 copy.
module tb_mag_sort_ctrl;
    typedef logic [3:0] word8_t [8];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready;
    logic [3:0] in_data;
    logic       in_ready, out_valid, out_last, busy;
    logic [3:0] out_data;
    logic [7:0] swap_cnt;

    logic       d_in_valid, d_out_ready;
    logic [3:0] d_in_data;
    logic       d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [3:0] d_out_data;
    logic [7:0] d_swap_cnt;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    mag_sort_ctrl #(.DEPTH(8), .DESCEND(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .swap_cnt(swap_cnt)
    );

    mag_sort_ctrl #(.DEPTH(8), .DESCEND(1'b1)) dut_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_last(d_out_last),
        .busy(d_busy), .swap_cnt(d_swap_cnt)
    );

    task automatic check_idle(input string tag);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle: got valid=%b last=%b busy=%b in_ready=%b, expected 0 0 0 1",
                     tag, out_valid, out_last, busy, in_ready);
        end
    endtask

    // Drives eight words; the last one is accepted on the next rising edge.
    task automatic load_words(input word8_t w);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w[k];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready word %0d: got %b expected 1", k, in_ready);
            end
        end
    endtask

    // Counts SORT cycles until out_valid rises; returns at that negedge.
    task automatic wait_sort(input bit hold, output int n);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
            if (out_valid === 1'b1) return;
            if (busy === 1'b1) n++;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL sort_in_ready cycle %0d: got %b expected 0", c, in_ready);
            end
        end
        errors++;
        $display("FAIL sort_timeout: out_valid still %b after 200 cycles, expected 1", out_valid);
    endtask

    // Drains exp_q; toggle=1 alternates out_ready 1,0,1,0...
    task automatic drain(input bit toggle, input string tag);
        bit         phase = 1'b1;
        bit         prev_stall = 1'b0;
        logic [3:0] prev_data = '0;
        logic       prev_last = 1'b0;
        int         c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            out_ready = toggle ? phase : 1'b1;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s drain_valid: got %b expected 1 (%0d words left)", tag, out_valid, exp_q.size());
            end else begin
                checks++;
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s out_data: got %0d expected %0d", tag, out_data, exp_q[0]);
                end
                checks++;
                if (out_last !== (exp_q.size() == 1)) begin
                    errors++;
                    $display("FAIL %s out_last: got %b expected %b", tag, out_last, exp_q.size() == 1);
                end
                if (prev_stall) begin
                    checks++;
                    if (out_data !== prev_data || out_last !== prev_last) begin
                        errors++;
                        $display("FAIL %s stall_hold: got %0d/%b expected %0d/%b",
                                 tag, out_data, out_last, prev_data, prev_last);
                    end
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                if (out_ready) void'(exp_q.pop_front());
            end
            phase = !phase;
            c++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain_count: got %0d words left expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        check_idle(tag);
    endtask

    task automatic run_batch(input word8_t w, input word8_t exp, input int exp_cycles,
                             input int exp_swaps, input bit toggle, input bit hold, input string tag);
        int n;
        load_words(w);
        wait_sort(hold, n);
        if (exp_cycles >= 0) begin
            checks++;
            if (n != exp_cycles) begin
                errors++;
                $display("FAIL %s sort_cycles: got %0d expected %0d", tag, n, exp_cycles);
            end
        end
        checks++;
        if (swap_cnt !== 8'(exp_swaps)) begin
            errors++;
            $display("FAIL %s swap_cnt: got %0d expected %0d", tag, swap_cnt, exp_swaps);
        end
        for (int k = 0; k < 8; k++) exp_q.push_back(exp[k]);
        drain(toggle, tag);
        checks++;
        if (swap_cnt !== 8'(exp_swaps)) begin
            errors++;
            $display("FAIL %s swap_cnt_held: got %0d expected %0d", tag, swap_cnt, exp_swaps);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        checks++;
        if (swap_cnt !== 8'd0 || out_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_values: got swap_cnt=%0d out_data=%0d expected 0 0", swap_cnt, out_data);
        end
    endtask

    task automatic test_reset_mid_sort();
        word8_t w = '{15, 14, 13, 12, 11, 10, 9, 8};
        word8_t c1 = '{3, 1, 4, 1, 5, 9, 2, 6};
        word8_t e1 = '{1, 1, 2, 3, 4, 5, 6, 9};
        load_words(w);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midsort_rst: got in_ready=%b busy=%b valid=%b expected 0 0 0", in_ready, busy, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midsort_release");
        checks++;
        if (swap_cnt !== 8'd0 || out_data !== 4'd0) begin
            errors++;
            $display("FAIL midsort_values: got swap_cnt=%0d out_data=%0d expected 0 0", swap_cnt, out_data);
        end
        run_batch(c1, e1, -1, 8, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_descend();
        int n = 0;
        int c = 0;
        logic [3:0] exp_w = 4'd15;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d_in_valid = 1'b1;
            d_in_data  = 4'(15 - k);
        end
        @(negedge clk);
        d_in_valid = 1'b0;
        while (d_out_valid !== 1'b1 && c < 200) begin
            if (d_busy === 1'b1) n++;
            c++;
            @(negedge clk);
        end
        checks++;
        if (n != 7 || d_swap_cnt !== 8'd0) begin
            errors++;
            $display("FAIL descend_sort: got cycles=%0d swap_cnt=%0d expected 7 0", n, d_swap_cnt);
        end
        d_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (d_out_valid !== 1'b1 || d_out_data !== exp_w || d_out_last !== (k == 7)) begin
                errors++;
                $display("FAIL descend_out %0d: got v=%b d=%0d l=%b expected 1 %0d %b",
                         k, d_out_valid, d_out_data, d_out_last, exp_w, k == 7);
            end
            exp_w = exp_w - 4'd1;
            @(negedge clk);
        end
        d_out_ready = 1'b0;
        checks++;
        if (d_out_valid !== 1'b0 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL descend_idle: got v=%b busy=%b expected 0 0", d_out_valid, d_busy);
        end
    endtask

    initial begin
        word8_t c1  = '{3, 1, 4, 1, 5, 9, 2, 6};
        word8_t e1  = '{1, 1, 2, 3, 4, 5, 6, 9};
        word8_t srt = '{0, 1, 2, 3, 4, 5, 6, 7};
        word8_t rev = '{15, 14, 13, 12, 11, 10, 9, 8};
        word8_t fwd = '{8, 9, 10, 11, 12, 13, 14, 15};
        word8_t sev = '{7, 7, 7, 7, 7, 7, 7, 7};

        test_reset();
        run_batch(c1, e1, -1, 8, 1'b0, 1'b0, "case1");
        run_batch(srt, srt, 7, 0, 1'b0, 1'b0, "sorted");
        run_batch(rev, fwd, 49, 28, 1'b0, 1'b0, "reverse");
        test_descend();
        run_batch(c1, e1, -1, 8, 1'b1, 1'b0, "backpressure");
        test_reset_mid_sort();
        run_batch(sev, sev, 7, 0, 1'b0, 1'b1, "all_sevens");
        run_batch(srt, srt, 7, 0, 1'b0, 1'b0, "back_to_back");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
